// File: rtl/fpmul_pkg.sv
// rtl/fpmul_pkg.sv - fp32 multiplier constants, flag indices and FSM/operand-class enums.
package fpmul_pkg;

    localparam int          FP_EXP_W  = 8;
    localparam int          FP_FRAC_W = 23;
    localparam int          FP_BIAS   = 127;
    localparam logic [31:0] FP_QNAN   = 32'h7FC00000;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_RND,
        ST_DONE
    } state_e;

    // Result class decided at unpack; SPC_NONE means the arithmetic path decides.
    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } spc_e;

endpackage

// File: rtl/vedic24.sv
// rtl/vedic24.sv - combinational 24x24 mantissa multiplier built from four 12x12 partial products.
module vedic24 (
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    output logic [47:0] p_o
);

    logic [23:0] pp_ll;
    logic [23:0] pp_lh;
    logic [23:0] pp_hl;
    logic [23:0] pp_hh;
    logic [24:0] pp_mid;

    assign pp_ll  = a_i[11:0]  * b_i[11:0];
    assign pp_lh  = a_i[11:0]  * b_i[23:12];
    assign pp_hl  = a_i[23:12] * b_i[11:0];
    assign pp_hh  = a_i[23:12] * b_i[23:12];
    assign pp_mid = {1'b0, pp_lh} + {1'b0, pp_hl};

    assign p_o = {pp_hh, 24'd0} + {11'd0, pp_mid, 12'd0} + {24'd0, pp_ll};

endmodule

// File: rtl/fpmul_seq.sv
// rtl/fpmul_seq.sv - sequenced fp32 multiplier: unpack, MUL, NORM, RND/pack, DONE handshake.
// Define FPMUL_FLAGS_EN to build the {NV,OF,UF,NX} flag logic; otherwise out_flags is tied low.
module fpmul_seq
    import fpmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_flags
);

    state_e                state_q,  state_d;
    spc_e                  spc_q,    spc_d;
    logic                  sign_q,   sign_d;
    logic signed [9:0]     exp_q,    exp_d;
    logic [23:0]           ma_q,     ma_d;
    logic [23:0]           mb_q,     mb_d;
    logic [47:0]           prod_q,   prod_d;
    logic [FP_FRAC_W-1:0]  frac_q,   frac_d;
    logic                  guard_q,  guard_d;
    logic                  sticky_q, sticky_d;
    logic [31:0]           data_q,   data_d;
`ifdef FPMUL_FLAGS_EN
    logic                  nv_q,     nv_d;
    logic [3:0]            flags_q,  flags_d;
`endif

    logic [FP_EXP_W-1:0] ea, eb;
    logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]         prod;
    logic                round_up, carry;
    logic [FP_FRAC_W-1:0] frac_sum, frac_rnd;
    logic signed [9:0]   e_rnd;

    assign ea     = in_a[30:23];
    assign eb     = in_b[30:23];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_nan  = (ea == 8'hFF) &&  (|in_a[22:0]);
    assign b_nan  = (eb == 8'hFF) &&  (|in_b[22:0]);
    assign a_inf  = (ea == 8'hFF) && !(|in_a[22:0]);
    assign b_inf  = (eb == 8'hFF) && !(|in_b[22:0]);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;
`ifdef FPMUL_FLAGS_EN
    assign out_flags = flags_q;
`else
    assign out_flags = 4'b0000;
`endif

    vedic24 u_mant_mul (
        .a_i (ma_q),
        .b_i (mb_q),
        .p_o (prod)
    );

    // The hidden bit is not stored, so a carry out of the fraction is the 2^24 overflow.
    assign round_up          = guard_q & (sticky_q | frac_q[0]);
    assign {carry, frac_sum} = {1'b0, frac_q} + {{FP_FRAC_W{1'b0}}, round_up};
    assign frac_rnd          = carry ? '0 : frac_sum;
    assign e_rnd             = carry ? exp_q + 10'sd1 : exp_q;

    always_comb begin
        state_d  = state_q;
        spc_d    = spc_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        prod_d   = prod_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
`ifdef FPMUL_FLAGS_EN
        nv_d     = nv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MUL;
                    sign_d  = in_a[31] ^ in_b[31];
                    exp_d   = $signed({2'b00, ea} + {2'b00, eb} - 10'd127);
                    ma_d    = a_zero ? 24'd0 : {1'b1, in_a[22:0]};
                    mb_d    = b_zero ? 24'd0 : {1'b1, in_b[22:0]};
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                        spc_d = SPC_NAN;
                    else if (a_inf || b_inf)
                        spc_d = SPC_INF;
                    else if (a_zero || b_zero)
                        spc_d = SPC_ZERO;
                    else
                        spc_d = SPC_NONE;
`ifdef FPMUL_FLAGS_EN
                    nv_d = (a_nan && !in_a[22]) || (b_nan && !in_b[22]) ||
                           (a_inf && b_zero) || (b_inf && a_zero);
`endif
                end
            end
            ST_MUL: begin
                state_d = ST_NORM;
                prod_d  = prod;
            end
            ST_NORM: begin
                state_d = ST_RND;
                if (prod_q[47]) begin
                    frac_d   = prod_q[46:24];
                    guard_d  = prod_q[23];
                    sticky_d = |prod_q[22:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    frac_d   = prod_q[45:23];
                    guard_d  = prod_q[22];
                    sticky_d = |prod_q[21:0];
                end
            end
            ST_RND:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
`ifdef FPMUL_FLAGS_EN
        flags_d = flags_q;
`endif
        if (state_q == ST_RND) begin
`ifdef FPMUL_FLAGS_EN
            flags_d = 4'b0000;
`endif
            case (spc_q)
                SPC_NAN: begin
                    data_d = FP_QNAN;
`ifdef FPMUL_FLAGS_EN
                    flags_d[FLG_NV] = nv_q;
`endif
                end
                SPC_INF:  data_d = {sign_q, 8'hFF, 23'd0};
                SPC_ZERO: data_d = {sign_q, 31'd0};
                default: begin
                    if (e_rnd >= 10'sd255) begin
                        data_d = {sign_q, 8'hFF, 23'd0};
`ifdef FPMUL_FLAGS_EN
                        flags_d[FLG_OF] = 1'b1;
                        flags_d[FLG_NX] = 1'b1;
`endif
                    end else if (e_rnd <= 10'sd0) begin
                        data_d = {sign_q, 31'd0};
`ifdef FPMUL_FLAGS_EN
                        flags_d[FLG_UF] = 1'b1;
                        flags_d[FLG_NX] = 1'b1;
`endif
                    end else begin
                        data_d = {sign_q, e_rnd[7:0], frac_rnd};
`ifdef FPMUL_FLAGS_EN
                        flags_d[FLG_NX] = guard_q | sticky_q;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            spc_q    <= SPC_NONE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            prod_q   <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            data_q   <= '0;
`ifdef FPMUL_FLAGS_EN
            nv_q     <= 1'b0;
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            spc_q    <= spc_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            prod_q   <= prod_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            data_q   <= data_d;
`ifdef FPMUL_FLAGS_EN
            nv_q     <= nv_d;
            flags_q  <= flags_d;
`endif
        end
    end

endmodule
